// File: rtl/video_timing_gen.sv
// Raster timing generator: blank/de, hsync/vsync, pixel coordinates and frame/line strobes.
// Latency: outputs are the registered decode of the counter state, one clk behind it.
// Backpressure: none; ce gates raster advance, and level outputs hold while ce=0.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          resync,
    output logic          blank,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] HA       = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA       = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
            $error("video_timing_gen: every active/porch/sync parameter must be >= 1");
        end
        if (CW < 1 || CW > 30 || (H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
            $error("video_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          act;
    logic          hs_a;
    logic          vs_a;
    logic          h_last;
    logic          v_last;

    always_comb begin
        act    = (hc < HA) && (vc < VA);
        hs_a   = (hc >= HS_START) && (hc < HS_END);
        // vs_a depends only on vc, so vsync moves only when hc wraps to 0
        vs_a   = (vc >= VS_START) && (vc < VS_END);
        h_last = (hc == H_LAST);
        v_last = (vc == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset || resync) begin
            hc          <= '0;
            vc          <= '0;
            de          <= 1'b0;
            blank       <= 1'b1;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (reset) begin
                frame_cnt <= 8'd0;
            end
        end else if (ce) begin
            if (h_last) begin
                hc <= '0;
                vc <= v_last ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
            de          <= act;
            blank       <= ~act;
            hsync       <= hs_a ? HS_POL : ~HS_POL;
            vsync       <= vs_a ? VS_POL : ~VS_POL;
            x           <= hc;
            y           <= vc;
            line_start  <= (hc == '0);
            frame_start <= (hc == '0) && (vc == '0);
            if ((hc == '0) && (vc == '0)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small 14x7 raster, both sync polarities, against a pixel-index reference model.
module tb_video_timing_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSW = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int CW  = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;
    logic resync = 1'b0;

    logic a_blank, a_de, a_hsync, a_vsync, a_ls, a_fs;
    logic b_blank, b_de, b_hsync, b_vsync, b_ls, b_fs;
    logic [CW-1:0] a_x, a_y, b_x, b_y;
    logic [7:0] a_fc, b_fc;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) u_pol0 (
        .clk(clk), .reset(reset), .ce(ce), .resync(resync),
        .blank(a_blank), .de(a_de), .hsync(a_hsync), .vsync(a_vsync),
        .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) u_pol1 (
        .clk(clk), .reset(reset), .ce(ce), .resync(resync),
        .blank(b_blank), .de(b_de), .hsync(b_hsync), .vsync(b_vsync),
        .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    int total = 0;
    int bad = 0;

    // Reference: raster position as a single pixel index into the frame
    int pos = 0;
    int ex = 0, ey = 0, efc = 0;
    bit e_de = 0, e_hs = 0, e_vs = 0, e_ls = 0, e_fs = 0;

    int cyc = 0;
    int last_fs = -1;
    int exp_period = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model(input bit r, input bit rs, input bit c);
        int mx, my;
        if (r || rs) begin
            pos = 0;
            e_de = 0; e_hs = 0; e_vs = 0; e_ls = 0; e_fs = 0;
            ex = 0; ey = 0;
            if (r) efc = 0;
        end else if (c) begin
            mx = pos % HT;
            my = pos / HT;
            ex = mx;
            ey = my;
            e_de = (mx < HA) && (my < VA);
            e_hs = (mx >= HA + HFP) && (mx < HA + HFP + HSW);
            e_vs = (my >= VA + VFP) && (my < VA + VFP + VSW);
            e_ls = (mx == 0);
            e_fs = (pos == 0);
            if (e_fs) efc = (efc + 1) % 256;
            pos = (pos + 1) % (HT * VT);
        end else begin
            e_ls = 0;
            e_fs = 0;
        end
    endtask

    task automatic step(input bit r, input bit rs, input bit c);
        reset = r;
        resync = rs;
        ce = c;
        @(posedge clk);
        model(r, rs, c);
        #1;
        chk("a_de", 32'(a_de), 32'(e_de));
        chk("a_blank", 32'(a_blank), 32'(!e_de));
        chk("a_hsync", 32'(a_hsync), 32'(!e_hs));
        chk("a_vsync", 32'(a_vsync), 32'(!e_vs));
        chk("a_x", 32'(a_x), 32'(ex));
        chk("a_y", 32'(a_y), 32'(ey));
        chk("a_line_start", 32'(a_ls), 32'(e_ls));
        chk("a_frame_start", 32'(a_fs), 32'(e_fs));
        chk("a_frame_cnt", 32'(a_fc), 32'(efc));
        chk("b_de", 32'(b_de), 32'(e_de));
        chk("b_hsync", 32'(b_hsync), 32'(e_hs));
        chk("b_vsync", 32'(b_vsync), 32'(e_vs));
        chk("b_x", 32'(b_x), 32'(ex));
        chk("b_y", 32'(b_y), 32'(ey));
        chk("b_frame_start", 32'(b_fs), 32'(e_fs));
        chk("b_frame_cnt", 32'(b_fc), 32'(efc));
        if (a_fs === 1'b1) begin
            if (exp_period != 0 && last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(exp_period));
            last_fs = cyc;
        end
        cyc++;
    endtask

    initial begin
        int saved_fc;
        int nfs;

        // Reset state, then continuous ce: frame period is HT*VT
        repeat (3) step(1, 0, 0);
        exp_period = HT * VT;
        last_fs = -1;
        for (int i = 0; i < 3 * HT * VT + 5; i++) step(0, 0, 1);

        // ce toggling 1,0: everything stretches by two
        step(1, 0, 0);
        exp_period = 2 * HT * VT;
        last_fs = -1;
        for (int i = 0; i < 6 * HT * VT + 5; i++) step(0, 0, (i % 2) == 0);

        // Random ce with sporadic resync and reset
        exp_period = 0;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);

        // Resync mid-frame at output pixel (5,2), applied while ce=0
        step(1, 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < 2 * HT * VT && !(a_x == 5 && a_y == 2); i++) step(0, 0, 1);
        chk("rs_at_x", 32'(a_x), 32'd5);
        chk("rs_at_y", 32'(a_y), 32'd2);
        saved_fc = int'(a_fc);
        step(0, 1, 0);
        chk("rs_de", 32'(a_de), 32'd0);
        chk("rs_hsync_idle", 32'(a_hsync), 32'd1);
        chk("rs_vsync_idle", 32'(a_vsync), 32'd1);
        chk("rs_b_hsync_idle", 32'(b_hsync), 32'd0);
        chk("rs_fc_hold", 32'(a_fc), 32'(saved_fc));
        step(0, 0, 1);
        chk("rs_x0", 32'(a_x), 32'd0);
        chk("rs_y0", 32'(a_y), 32'd0);
        chk("rs_fs", 32'(a_fs), 32'd1);
        chk("rs_fc_inc", 32'(a_fc), 32'((saved_fc + 1) % 256));

        // frame_cnt wrap over 257 frames
        step(1, 0, 0);
        exp_period = HT * VT;
        last_fs = -1;
        nfs = 0;
        for (int i = 0; i < 258 * HT * VT && nfs < 257; i++) begin
            step(0, 0, 1);
            if (a_fs === 1'b1) begin
                nfs++;
                if (nfs == 255) chk("fc_255", 32'(a_fc), 32'd255);
                if (nfs == 256) chk("fc_wrap", 32'(a_fc), 32'd0);
            end
        end
        chk("fc_frames_seen", 32'(nfs), 32'd257);

        // One-clk reset at the last active pixel, then a clean frame
        exp_period = 0;
        for (int i = 0; i < 2 * HT * VT && !(a_x == HA - 1 && a_y == VA - 1); i++) step(0, 0, 1);
        chk("rst_at_x", 32'(a_x), 32'(HA - 1));
        chk("rst_at_y", 32'(a_y), 32'(VA - 1));
        step(1, 0, 1);
        chk("rst_de", 32'(a_de), 32'd0);
        chk("rst_blank", 32'(a_blank), 32'd1);
        chk("rst_fc", 32'(a_fc), 32'd0);
        step(0, 0, 1);
        chk("rst_x0", 32'(a_x), 32'd0);
        chk("rst_y0", 32'(a_y), 32'd0);
        chk("rst_fs", 32'(a_fs), 32'd1);
        chk("rst_fc1", 32'(a_fc), 32'd1);
        for (int i = 0; i < HT * VT; i++) step(0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
